// File: rtl/rr_grant_arb.sv
// rr_grant_arb: round-robin arbiter with a registered one-hot grant held until done or request drop.
// Optional grant watchdog enabled by defining RR_GRANT_ARB_TIMEOUT_EN.
`default_nettype none

module rr_grant_arb #(
    parameter int W    = 16,
    parameter int IDXW = 4,
    parameter int TMO  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    req,
    input  logic            ls_mode,
    input  logic            done,
    output logic [W-1:0]    gnt,
    output logic            gnt_vld,
    output logic [IDXW-1:0] gnt_idx
`ifdef RR_GRANT_ARB_TIMEOUT_EN
    ,
    output logic            tmo_err
`endif
);

    generate
        if (W < 2 || W > 128 || IDXW != $clog2(W) || TMO < 1) begin : g_param_check
            $error("rr_grant_arb: illegal W/IDXW/TMO combination");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    gnt_q, gnt_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] last_q, last_d;
    logic            last_vld_q, last_vld_d;
    logic            release_w;

    logic [IDXW-1:0] m_idx_w, u_idx_w, win_idx_w;
    logic            m_found_w;

`ifdef RR_GRANT_ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TMO + 1);
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            tmo_q, tmo_d;
`endif

    // Masked search finds the next candidate past the last winner; the
    // unmasked result is the wrap-around fallback.
    always_comb begin
        m_found_w = 1'b0;
        m_idx_w   = '0;
        u_idx_w   = '0;
        if (!ls_mode) begin
            for (int i = 0; i < W; i++) begin
                if (req[i]) begin
                    u_idx_w = IDXW'(i);
                    if (last_vld_q && (IDXW'(i) < last_q)) begin
                        m_found_w = 1'b1;
                        m_idx_w   = IDXW'(i);
                    end
                end
            end
        end else begin
            for (int i = W - 1; i >= 0; i--) begin
                if (req[i]) begin
                    u_idx_w = IDXW'(i);
                    if (last_vld_q && (IDXW'(i) > last_q)) begin
                        m_found_w = 1'b1;
                        m_idx_w   = IDXW'(i);
                    end
                end
            end
        end
        win_idx_w = m_found_w ? m_idx_w : u_idx_w;
    end

    assign release_w = done || !req[idx_q];

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        idx_d      = idx_q;
        last_d     = last_q;
        last_vld_d = last_vld_q;
`ifdef RR_GRANT_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        tmo_d      = 1'b0;
`endif
        if (state_q == IDLE) begin
            if (|req) begin
                state_d    = HOLD;
                gnt_d      = W'(1) << win_idx_w;
                idx_d      = win_idx_w;
                last_d     = win_idx_w;
                last_vld_d = 1'b1;
`ifdef RR_GRANT_ARB_TIMEOUT_EN
                cnt_d      = '0;
`endif
            end
        end else begin
            if (release_w) begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
`ifdef RR_GRANT_ARB_TIMEOUT_EN
            end else if (cnt_q == CNTW'(TMO - 1)) begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                tmo_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            idx_q      <= '0;
            last_q     <= '0;
            last_vld_q <= 1'b0;
`ifdef RR_GRANT_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            tmo_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
`ifdef RR_GRANT_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign gnt_vld = (state_q == HOLD);
    assign gnt_idx = idx_q;
`ifdef RR_GRANT_ARB_TIMEOUT_EN
    assign tmo_err = tmo_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_grant_arb.sv
// Bench for rr_grant_arb (W=8): cycle model compared every cycle plus directed literal checks.
`default_nettype none

module tb_rr_grant_arb;

    localparam int W    = 8;
    localparam int IDXW = 3;
    localparam int TMO  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [W-1:0]    req;
    logic            ls_mode;
    logic            done;
    logic [W-1:0]    gnt;
    logic            gnt_vld;
    logic [IDXW-1:0] gnt_idx;
`ifdef RR_GRANT_ARB_TIMEOUT_EN
    logic            tmo_err;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    rr_grant_arb #(.W(W), .IDXW(IDXW), .TMO(TMO)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ls_mode (ls_mode),
        .done    (done),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
`ifdef RR_GRANT_ARB_TIMEOUT_EN
        ,
        .tmo_err (tmo_err)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: circular scan starting just past the last winner.
    bit       m_hold;
    int       m_idx;
    int       m_last;
    bit       m_last_vld;
    int       m_cnt;
    bit       m_tmo;

    function automatic int pick(input logic [W-1:0] r, input bit lsb, input bit lv, input int last);
        int start;
        int c;
        start = lv ? last : (lsb ? W - 1 : 0);
        for (int k = 1; k <= W; k++) begin
            c = lsb ? (start + k) % W : (start - k + W) % W;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_hold = 0; m_idx = 0; m_last_vld = 0; m_last = 0; m_cnt = 0; m_tmo = 0;
        end else begin
            m_tmo = 0;
            if (!m_hold) begin
                if (req != 0) begin
                    m_idx = pick(req, ls_mode, m_last_vld, m_last);
                    m_last = m_idx; m_last_vld = 1; m_hold = 1; m_cnt = 0;
                end
            end else if (done || !req[m_idx]) begin
                m_hold = 0; m_idx = 0;
            end else begin
`ifdef RR_GRANT_ARB_TIMEOUT_EN
                if (m_cnt == TMO - 1) begin
                    m_hold = 0; m_idx = 0; m_tmo = 1;
                end else m_cnt++;
`else
                m_cnt++;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [W-1:0] eg;
            eg = m_hold ? (W'(1) << m_idx) : '0;
            n_cmp++;
            if (gnt !== eg || gnt_vld !== m_hold || gnt_idx !== IDXW'(m_idx)) begin
                n_err++;
                $display("FAIL model t=%0t: got gnt=%h vld=%b idx=%0d expected gnt=%h vld=%b idx=%0d",
                         $time, gnt, gnt_vld, gnt_idx, eg, m_hold, m_idx);
            end
`ifdef RR_GRANT_ARB_TIMEOUT_EN
            n_cmp++;
            if (tmo_err !== m_tmo) begin
                n_err++;
                $display("FAIL model_tmo t=%0t: got %b expected %b", $time, tmo_err, m_tmo);
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; done = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_vld", 32'(gnt_vld), 32'h0);
        chk("reset_idx", 32'(gnt_idx), 32'h0);
    endtask

    task automatic grant_cycle(input string name, input logic [W-1:0] eg, input int ei);
        tick();
        chk(name, 32'(gnt), 32'(eg));
        chk(name, 32'(gnt_idx), 32'(ei));
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk({name, "_rel"}, 32'(gnt), 32'h0);
    endtask

    logic [W-1:0] tbl_req  [16] = '{8'h94, 8'hFF, 8'h81, 8'h00, 8'h3C, 8'h3C, 8'h42, 8'h18,
                                    8'hFF, 8'h01, 8'h80, 8'hA5, 8'h5A, 8'h00, 8'h7E, 8'hC3};
    bit           tbl_done [16] = '{0, 1, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 1, 1, 0, 1};

    initial begin
        rst = 1'b1; req = '0; ls_mode = 1'b0; done = 1'b0;
        tick();
        chk_en = 1'b1;
        do_reset();

        // MSB-first rotation
        ls_mode = 1'b0; req = 8'b1001_0100;
        grant_cycle("msb0", 8'h80, 7);
        grant_cycle("msb1", 8'h10, 4);
        grant_cycle("msb2", 8'h04, 2);
        grant_cycle("msb3", 8'h80, 7);

        // LSB-first rotation from a fresh reset
        do_reset();
        ls_mode = 1'b1; req = 8'b1001_0100;
        grant_cycle("lsb0", 8'h04, 2);
        grant_cycle("lsb1", 8'h10, 4);
        grant_cycle("lsb2", 8'h80, 7);
        grant_cycle("lsb3", 8'h04, 2);

        // Single request latency, release by request drop, done ignored in IDLE
        do_reset();
        ls_mode = 1'b0; req = 8'h01;
        tick();
        chk("lat_gnt", 32'(gnt), 32'h01);
        chk("lat_vld", 32'(gnt_vld), 32'h1);
        tick(); tick();
        req = 8'h00;
        tick();
        chk("drop_gnt", 32'(gnt), 32'h0);
        chk("drop_vld", 32'(gnt_vld), 32'h0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("idle_done", 32'(gnt_vld), 32'h0);

        // ls_mode changes during HOLD have no effect
        do_reset();
        ls_mode = 1'b0; req = 8'h20;
        tick();
        chk("hold5", 32'(gnt), 32'h20);
        req = 8'hFF; ls_mode = 1'b1;
        tick();
        chk("hold5_a", 32'(gnt), 32'h20);
        ls_mode = 1'b0;
        tick();
        chk("hold5_b", 32'(gnt), 32'h20);
        ls_mode = 1'b1; done = 1'b1;
        tick();
        done = 1'b0;
        chk("hold5_rel", 32'(gnt), 32'h0);
        tick();
        chk("ls_next", 32'(gnt), 32'h40);
        done = 1'b1;
        tick();
        done = 1'b0; ls_mode = 1'b0;
        tick();
        chk("ms_next", 32'(gnt), 32'h20);

        // Reset mid-HOLD, then last winner is invalid
        do_reset();
        req = 8'h08;
        tick();
        chk("pre_rst", 32'(gnt), 32'h08);
        rst = 1'b1; done = 1'b1;
        tick();
        chk("rst_hold_gnt", 32'(gnt), 32'h0);
        chk("rst_hold_vld", 32'(gnt_vld), 32'h0);
        rst = 1'b0; done = 1'b0; req = 8'h0C; ls_mode = 1'b0;
        tick();
        chk("post_rst", 32'(gnt), 32'h08);

`ifdef RR_GRANT_ARB_TIMEOUT_EN
        do_reset();
        req = 8'h02;
        tick();
        chk("tmo_g0", 32'(gnt), 32'h02);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("tmo_hold", 32'(gnt), 32'h02);
            chk("tmo_quiet", 32'(tmo_err), 32'h0);
        end
        tick();
        chk("tmo_clr", 32'(gnt), 32'h0);
        chk("tmo_err", 32'(tmo_err), 32'h1);
        tick();
        chk("tmo_regrant", 32'(gnt), 32'h02);
        chk("tmo_pulse", 32'(tmo_err), 32'h0);
`endif

        // Mixed table, checked by the model every cycle
        do_reset();
        for (int t = 0; t < 16; t++) begin
            req = tbl_req[t];
            done = tbl_done[t];
            ls_mode = t[2];
            tick();
        end
        done = 1'b0; req = '0;
        tick(); tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rr_grant_arb.md
RR_GRANT_ARB -- requirements
Module: rr_grant_arb

Interface
REQ-001 Parameter: W, default 16, number of requesters (legal 2..128).
REQ-002 Parameter: IDXW, default 4, width of binary grant index (must equal ceil(log2(W))).
REQ-003 Parameter: TMO, default 64, grant watchdog limit in cycles (used only with REQ-030).
REQ-004 Port: clk  input  1  single clock, all logic rising-edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: req  input  W  per-requester request, level.
REQ-007 Port: ls_mode  input  1  0 = MSB-first priority, 1 = LSB-first priority.
REQ-008 Port: done  input  1  pulse from granted requester releasing the grant.
REQ-009 Port: gnt  output  W  one-hot grant, registered.
REQ-010 Port: gnt_vld  output  1  high while a grant is held.
REQ-011 Port: gnt_idx  output  IDXW  binary index of the set gnt bit, registered.
REQ-012 Port: tmo_err  output  1  one-cycle watchdog pulse (present only with REQ-030).

Function
REQ-013 FSM states IDLE and HOLD; reset state IDLE.
REQ-014 IDLE with req != 0: pick a winner, go to HOLD; gnt, gnt_idx and gnt_vld update on the following edge (latency 1 cycle from req to gnt).
REQ-015 IDLE with req == 0: stay IDLE, outputs stay zero.
REQ-016 Winner selection, ls_mode=0: highest-index set bit among req bits strictly below last winner index; if none, highest-index set bit of req.
REQ-017 Winner selection, ls_mode=1: lowest-index set bit among req bits strictly above last winner index; if none, lowest-index set bit of req.
REQ-018 No last winner since reset: fall straight to the unmasked search of REQ-016/017.
REQ-019 ls_mode sampled only in the IDLE arbitration cycle; changes during HOLD have no effect.
REQ-020 gnt is one-hot or all-zero in every cycle; gnt_idx equals the set position, and is 0 when gnt_vld=0.
REQ-021 HOLD: grant held until done=1, or req[gnt_idx]=0, whichever first; release clears gnt/gnt_vld/gnt_idx on next edge and returns to IDLE.
REQ-022 After release, at least one IDLE cycle precedes the next grant (no back-to-back grant edges).
REQ-023 done in IDLE is ignored; done and req drop in same cycle count as one release.
REQ-024 Last winner index updates only when a grant is issued; it survives release.
REQ-025 Requests of non-granted requesters during HOLD are neither lost nor latched; they re-arbitrate from live req in IDLE.

Reset
REQ-026 rst=1 at an edge: state IDLE, gnt=0, gnt_vld=0, gnt_idx=0, tmo_err=0, last-winner marked invalid, watchdog count 0.
REQ-027 rst mid-HOLD drops the grant on that edge, no release handshake required.
REQ-028 rst dominates done, req and watchdog in the same cycle.
REQ-029 First grant possible on the first edge after rst deasserts with req != 0 (output one cycle later per REQ-014).

Configuration
REQ-030 Macro RR_GRANT_ARB_TIMEOUT_EN defined: HOLD counter counts cycles in HOLD; on reaching TMO cycles without release, grant is forcibly released as in REQ-021 and tmo_err pulses 1 cycle coincident with the clearing edge.
REQ-031 Macro undefined: no counter, no tmo_err port, grants held indefinitely until done or req drop.

Verification
REQ-032 W=8, ls_mode=0, req=8'b1001_0100 held, done pulse 2 cycles after each grant -> gnt sequence 0x80,0x10,0x04,0x80; gnt_idx 7,4,2,7.
REQ-033 W=8, ls_mode=1, same req -> gnt sequence 0x04,0x10,0x80,0x04; gnt_idx 2,4,7,2.
REQ-034 After reset, req=0x01 in cycle 0 -> gnt=0x01, gnt_vld=1 in cycle 1; req=0x00 in cycle 3 -> gnt=0, gnt_vld=0 in cycle 4.
REQ-035 Grant to idx 5 active, ls_mode toggled and req=0xFF during HOLD -> gnt stays 0x20 until done; next winner uses ls_mode value at the IDLE cycle.
REQ-036 rst asserted while gnt=0x08 -> gnt=0, gnt_vld=0 next edge; after rst deasserts with req=0x0C, ls_mode=0 -> gnt=0x08 (last winner invalid).
REQ-037 With RR_GRANT_ARB_TIMEOUT_EN, TMO=4, req=0x02 held, no done -> gnt=0x02 for 4 cycles, then gnt=0 with tmo_err=1 for one cycle, then regrant 0x02 after one IDLE cycle.
